// File: rtl/altair_pkg.sv
// altair_pkg: shared loader state encoding and HPS ioctl address width
package altair_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, WRITE, HOLD} state_t;
  localparam int IOCTL_ADDR_W = 25;
endpackage

// File: rtl/hold_counter.sv
// hold_counter: loadable down-counter that stops at zero and flags terminal count
module hold_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tc
);
  logic [W-1:0] count_q, count_d;
  always_comb count_d = load ? load_val : (en && count_q != '0) ? count_q - 1'b1 : count_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) count_q <= '0;
    else count_q <= count_d;
  assign tc = count_q == '0;
endmodule

// File: rtl/ioctl_prg_loader.sv
// ioctl_prg_loader: copies an HPS ioctl download into RAM, holding the CPU in reset
// until the download ends plus a programmable settle time.
module ioctl_prg_loader
  import altair_pkg::*;
#(
  parameter int         MEM_DEPTH   = 65536,
  parameter int         ADDR_W      = 16,
  parameter int         BASE_ADDR   = 0,
  parameter int         HOLD_CYCLES = 16,
  parameter logic [7:0] INDEX_MASK  = 8'hFF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ioctl_download,
  input  logic [7:0]              ioctl_index,
  input  logic                    ioctl_wr,
  input  logic [IOCTL_ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]              ioctl_dout,
  output logic                    ioctl_wait,
  output logic                    mem_req,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [7:0]              mem_wdata,
  input  logic                    mem_ack,
  output logic                    machine_reset,
  output logic [7:0]              prg_sel,
  output logic [ADDR_W:0]         byte_count,
  output logic                    overflow,
  output logic                    load_done
);
  localparam int HC_W = $clog2(HOLD_CYCLES + 1);
  state_t state_q, state_d;
  logic dl_q, wait_q, wait_d, req_q, req_d, mrst_q, mrst_d, ov_q, ov_d, done_q, done_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d, sel_q, sel_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic start, in_range, hold_tc;
  assign start = ioctl_download && !dl_q && (ioctl_index & ~INDEX_MASK) == 8'h00;
  assign in_range = ioctl_addr < IOCTL_ADDR_W'(MEM_DEPTH);
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    req_d   = req_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    ov_d    = ov_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE, HOLD: begin
        if (start) begin
          state_d = LOAD;
          sel_d   = ioctl_index;
          cnt_d   = '0;
          ov_d    = 1'b0;
        end else if (state_q == HOLD && hold_tc) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      LOAD: begin
        if (ioctl_wr && in_range) begin
          state_d = WRITE;
          req_d   = 1'b1;
          wait_d  = 1'b1;
          addr_d  = ADDR_W'(BASE_ADDR) + ioctl_addr[ADDR_W-1:0];
          wdata_d = ioctl_dout;
        end else begin
          ov_d    = ov_q | ioctl_wr;
          state_d = ioctl_download ? LOAD : HOLD;
        end
      end
      WRITE: begin
        // a download that ended mid-write is only noticed once the write lands
        if (mem_ack) begin
          req_d   = 1'b0;
          wait_d  = 1'b0;
          cnt_d   = (cnt_q == (ADDR_W+1)'(MEM_DEPTH)) ? cnt_q : cnt_q + 1'b1;
          state_d = ioctl_download ? LOAD : HOLD;
        end
      end
      default: state_d = IDLE;
    endcase
    mrst_d = state_d != IDLE;
  end
  hold_counter #(.W(HC_W)) u_hold (
    .clk      (clk),
    .reset    (reset),
    .load     (state_d == HOLD && state_q != HOLD),
    .load_val (HC_W'(HOLD_CYCLES - 1)),
    .en       (state_q == HOLD),
    .tc       (hold_tc)
  );
  // edge detector resets high so a download already in progress is not picked up
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      dl_q    <= 1'b1;
      wait_q  <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      ov_q    <= 1'b0;
      done_q  <= 1'b0;
      mrst_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dl_q    <= ioctl_download;
      wait_q  <= wait_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      ov_q    <= ov_d;
      done_q  <= done_d;
      mrst_q  <= mrst_d;
    end
  assign ioctl_wait    = wait_q;
  assign mem_req       = req_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign machine_reset = mrst_q;
  assign prg_sel       = sel_q;
  assign byte_count    = cnt_q;
  assign overflow      = ov_q;
  assign load_done     = done_q;
endmodule

// File: tb/tb_ioctl_prg_loader.sv
// tb_ioctl_prg_loader: directed checks of the ioctl loader with a 256-byte RAM at base 0x40
module tb_ioctl_prg_loader;
  logic clk = 0, reset = 0, ioctl_download = 0, ioctl_wr = 0, mem_ack = 0;
  logic [7:0] ioctl_index = 0, ioctl_dout = 0;
  logic [24:0] ioctl_addr = 0;
  logic ioctl_wait, mem_req, machine_reset, overflow, load_done;
  logic [7:0] mem_addr, mem_wdata, prg_sel;
  logic [8:0] byte_count;
  int tests = 0, fails = 0;

  ioctl_prg_loader #(
    .MEM_DEPTH(256), .ADDR_W(8), .BASE_ADDR(8'h40), .HOLD_CYCLES(4), .INDEX_MASK(8'h01)
  ) dut (
    .clk(clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait), .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .machine_reset(machine_reset), .prg_sel(prg_sel),
    .byte_count(byte_count), .overflow(overflow), .load_done(load_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " mem_req"}, 32'(mem_req), 0);
    check({tag, " wait"}, 32'(ioctl_wait), 0);
    check({tag, " mem_addr"}, 32'(mem_addr), 0);
    check({tag, " mem_wdata"}, 32'(mem_wdata), 0);
    check({tag, " machine_reset"}, 32'(machine_reset), 0);
    check({tag, " prg_sel"}, 32'(prg_sel), 0);
    check({tag, " byte_count"}, 32'(byte_count), 0);
    check({tag, " overflow"}, 32'(overflow), 0);
    check({tag, " load_done"}, 32'(load_done), 0);
  endtask

  initial begin
    #2 reset = 1;
    tick;
    tick;
    check_idle_outputs("rst");
    reset = 0;
    tick;
    // three bytes, ack in the first request cycle
    ioctl_index = 8'h01;
    ioctl_download = 1;
    tick;
    check("a start machine_reset", 32'(machine_reset), 1);
    check("a prg_sel", 32'(prg_sel), 8'h01);
    for (int i = 0; i < 3; i++) begin
      ioctl_wr = 1;
      ioctl_addr = 25'(i);
      ioctl_dout = 8'hA0 + 8'(i);
      tick;
      ioctl_wr = 0;
      check("a mem_req", 32'(mem_req), 1);
      check("a wait", 32'(ioctl_wait), 1);
      check("a mem_addr", 32'(mem_addr), 32'h40 + 32'(i));
      check("a mem_wdata", 32'(mem_wdata), 32'hA0 + 32'(i));
      mem_ack = 1;
      tick;
      mem_ack = 0;
      check("a req drop", 32'(mem_req), 0);
      check("a wait drop", 32'(ioctl_wait), 0);
      check("a byte_count", 32'(byte_count), 32'(i + 1));
    end
    ioctl_download = 0;
    for (int k = 1; k <= 5; k++) begin
      tick;
      check("a load_done", 32'(load_done), 32'(k == 5));
      check("a hold machine_reset", 32'(machine_reset), 32'(k < 5));
    end
    tick;
    check("a load_done pulse", 32'(load_done), 0);
    check("a byte_count held", 32'(byte_count), 3);
    check("a prg_sel held", 32'(prg_sel), 8'h01);
    // out-of-range byte, then a byte with a late ack and a stray strobe
    ioctl_download = 1;
    tick;
    check("b overflow clear", 32'(overflow), 0);
    check("b byte_count clear", 32'(byte_count), 0);
    ioctl_wr = 1;
    ioctl_addr = 25'd300;
    ioctl_dout = 8'hEE;
    tick;
    ioctl_wr = 0;
    check("b oor mem_req", 32'(mem_req), 0);
    check("b oor wait", 32'(ioctl_wait), 0);
    check("b overflow", 32'(overflow), 1);
    check("b oor byte_count", 32'(byte_count), 0);
    ioctl_wr = 1;
    ioctl_addr = 25'd5;
    ioctl_dout = 8'h5A;
    tick;
    ioctl_wr = 0;
    for (int j = 1; j <= 6; j++) begin
      check("c wait", 32'(ioctl_wait), 1);
      check("c mem_req", 32'(mem_req), 1);
      check("c mem_addr", 32'(mem_addr), 32'h45);
      check("c mem_wdata", 32'(mem_wdata), 32'h5A);
      if (j == 2) begin
        ioctl_wr = 1;
        ioctl_addr = 25'd7;
        ioctl_dout = 8'h77;
      end else ioctl_wr = 0;
      mem_ack = (j == 6);
      tick;
    end
    mem_ack = 0;
    check("c wait drop", 32'(ioctl_wait), 0);
    check("c byte_count", 32'(byte_count), 1);
    check("c overflow sticky", 32'(overflow), 1);
    tick;
    check("c stray wr ignored", 32'(mem_req), 0);
    // download ends while a write is pending
    ioctl_wr = 1;
    ioctl_addr = 25'd6;
    ioctl_dout = 8'h66;
    tick;
    ioctl_wr = 0;
    ioctl_download = 0;
    tick;
    check("d write pending", 32'(mem_req), 1);
    check("d machine_reset", 32'(machine_reset), 1);
    mem_ack = 1;
    tick;
    mem_ack = 0;
    check("d req drop", 32'(mem_req), 0);
    check("d byte_count", 32'(byte_count), 2);
    for (int k = 1; k <= 4; k++) begin
      check("d hold machine_reset", 32'(machine_reset), 1);
      tick;
      check("d load_done", 32'(load_done), 32'(k == 4));
    end
    check("d idle machine_reset", 32'(machine_reset), 0);
    // non-matching index is ignored
    ioctl_index = 8'h05;
    ioctl_download = 1;
    for (int k = 0; k < 3; k++) begin
      tick;
      check("e machine_reset", 32'(machine_reset), 0);
    end
    check("e prg_sel", 32'(prg_sel), 8'h01);
    check("e byte_count", 32'(byte_count), 2);
    ioctl_download = 0;
    tick;
    // new download during HOLD restarts without load_done
    ioctl_index = 8'h01;
    ioctl_download = 1;
    tick;
    ioctl_download = 0;
    tick;
    tick;
    ioctl_download = 1;
    for (int k = 0; k < 5; k++) begin
      tick;
      check("f machine_reset", 32'(machine_reset), 1);
      check("f no load_done", 32'(load_done), 0);
    end
    // reset in the middle of a write with download held high
    ioctl_wr = 1;
    ioctl_addr = 25'd1;
    ioctl_dout = 8'h11;
    tick;
    ioctl_wr = 0;
    check("g mem_req", 32'(mem_req), 1);
    check("g mem_addr", 32'(mem_addr), 32'h41);
    reset = 1;
    #1;
    check_idle_outputs("g rst");
    tick;
    reset = 0;
    for (int k = 0; k < 3; k++) begin
      tick;
      check("g no relaunch", 32'(machine_reset), 0);
    end
    ioctl_download = 0;
    tick;
    ioctl_download = 1;
    tick;
    check("g relaunch", 32'(machine_reset), 1);
    check("g prg_sel", 32'(prg_sel), 8'h01);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ioctl_prg_loader.md
IOCTL_PRG_LOADER -- requirements
Module: ioctl_prg_loader

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 65536, the number of loadable bytes (power of two, at most 65536).
REQ-002 SHALL have parameter ADDR_W, default 16, the memory address width (log2 of MEM_DEPTH).
REQ-003 SHALL have parameter BASE_ADDR, default 0, the memory address of file byte 0; the sum wraps modulo MEM_DEPTH.
REQ-004 SHALL have parameter HOLD_CYCLES, default 16, the cycles machine_reset stays high after the download ends (at least 1).
REQ-005 SHALL have parameter INDEX_MASK, 8 bits, default 8'hFF, the ioctl_index values that are accepted (a match is index & ~INDEX_MASK == 0).
REQ-006 Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
ioctl_download  in  1  HPS download in progress
ioctl_index  in  8  file slot index
ioctl_wr  in  1  one-cycle byte strobe
ioctl_addr  in  25  file byte offset
ioctl_dout  in  8  file byte
ioctl_wait  out  1  stall request to HPS
mem_req  out  1  write request to RAM
mem_addr  out  ADDR_W  write address
mem_wdata  out  8  write data
mem_ack  in  1  RAM write accepted (single cycle)
machine_reset  out  1  hold the CPU in reset
prg_sel  out  8  index latched at download start
byte_count  out  ADDR_W+1  bytes written in the current or last load
overflow  out  1  sticky: a byte was dropped for being out of range
load_done  out  1  one-cycle pulse at the end of a load

Function
REQ-007 SHALL implement the states IDLE, LOAD, WRITE and HOLD.
REQ-008 IDLE to LOAD: on a rising edge of ioctl_download with an index match; prg_sel latches ioctl_index, and byte_count and overflow clear.
REQ-009 A download with a non-matching index SHALL be ignored entirely, with no outputs changed.
REQ-010 In LOAD, when ioctl_wr is high and ioctl_addr < MEM_DEPTH, the byte SHALL be accepted: mem_addr = BASE_ADDR + ioctl_addr[ADDR_W-1:0], mem_wdata = ioctl_dout, mem_req and ioctl_wait go high on the next cycle, and the state goes to WRITE.
REQ-011 In LOAD, when ioctl_wr is high and ioctl_addr >= MEM_DEPTH, the byte SHALL be dropped: overflow is set, and there is no mem_req and no ioctl_wait.
REQ-012 In WRITE, mem_req, mem_addr and mem_wdata SHALL hold stable until mem_ack is seen.
REQ-013 On mem_ack, the cycle after it: mem_req and ioctl_wait go low, byte_count increments, and the state returns to LOAD.
REQ-014 A mem_ack in the first cycle of mem_req SHALL be legal, giving a minimum of 2 cycles per byte.
REQ-015 ioctl_wr while in WRITE SHALL not occur, because ioctl_wait is high; if it does occur it SHALL be ignored.
REQ-016 ioctl_download falling in LOAD SHALL move the state to HOLD.
REQ-017 ioctl_download falling in WRITE SHALL complete the write and then move to HOLD instead of LOAD.
REQ-018 HOLD SHALL count HOLD_CYCLES cycles, then go to IDLE with load_done high for exactly 1 cycle.
REQ-019 A new matching download rising edge during HOLD SHALL restart at LOAD, with no load_done pulse.
REQ-020 machine_reset SHALL be high in LOAD, WRITE and HOLD, and low in IDLE.
REQ-021 byte_count SHALL saturate at MEM_DEPTH and never wrap.
REQ-022 prg_sel, byte_count and overflow SHALL hold their values in IDLE until the next accepted download.

Reset
REQ-023 Asynchronous reset SHALL force: state IDLE, ioctl_wait=0, mem_req=0, mem_addr=0, mem_wdata=0, machine_reset=0, prg_sel=0, byte_count=0, overflow=0, load_done=0, hold counter=0.
REQ-024 Reset during WRITE SHALL abandon the write, with mem_req low immediately.
REQ-025 After reset is released, a download that is already high SHALL NOT start a load until a fresh rising edge is seen; the edge detector register resets to 1.

Structure
REQ-026 The state enumeration and the IOCTL_ADDR_W=25 constant SHALL live in the shared package altair_pkg.
REQ-027 One sub-module SHALL exist: hold_counter, a parametrised down-counter with load and terminal-count outputs, used for HOLD.
REQ-028 The implementation SHALL be single clock domain, with all outputs registered.

Verification
REQ-029 MEM_DEPTH=256, BASE_ADDR=8'h40, download of 3 bytes at offsets 0..2 with mem_ack in the same cycle -> writes to 0x40,0x41,0x42; byte_count=3; load_done pulses HOLD_CYCLES+1 cycles after download falls.
REQ-030 Byte at offset 300 with MEM_DEPTH=256 -> no mem_req, overflow=1, byte_count unchanged.
REQ-031 mem_ack delayed 5 cycles -> ioctl_wait high for 6 cycles, and mem_addr and mem_wdata stable throughout.
REQ-032 ioctl_download falls while in WRITE -> write completes, then HOLD; machine_reset stays high continuously until load_done.
REQ-033 ioctl_index=8'h05 with INDEX_MASK=8'h01 -> ignored: machine_reset stays 0 and prg_sel is unchanged.
REQ-034 reset asserted mid-WRITE with download held high -> all outputs at reset values; no load after release until download toggles low then high.
